// File: rtl/uart_loop_fifo.sv
// Byte FIFO between uart_rx and uart_tx: buffers received bytes and launches
// them to the transmitter one at a time, waiting for each frame to finish.
module uart_loop_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_W-1:0]     rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  tx_done_i,
  input  logic                  ovf_clr_i,
  output logic                  tx_start_o,
  output logic [DATA_W-1:0]     tx_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int                  Depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CntOne    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_e;

  state_e                  state_q;
  logic [DATA_W-1:0]       mem_q [Depth];
  logic [DEPTH_LOG2-1:0]   wp_q, wp_d;
  logic [DEPTH_LOG2-1:0]   rp_q, rp_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    tx_start_q;
  logic [DATA_W-1:0]       tx_data_q;

  logic pop, push, drop, isEmpty, isFull;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == FullCount);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a byte.
  assign pop  = (state_q == IDLE) && !isEmpty;
  assign push = rx_valid_i && (!isFull || pop);
  assign drop = rx_valid_i && isFull && !pop;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wp_d = wp_q + PtrOne;
    if (pop)  rp_d = rp_q + PtrOne;
    if (push && !pop)      count_d = count_q + CntOne;
    else if (pop && !push) count_d = count_q - CntOne;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clr_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Launch FSM; the read of mem_q sees the old entry even when a push lands on the same slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_start_q <= 1'b0;
          if (pop) begin
            tx_data_q  <= mem_q[rp_q];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          tx_start_q <= 1'b0;
          if (tx_done_i) state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign count_o    = count_q;
  assign empty_o    = isEmpty;
  assign full_o     = isFull;
  assign overflow_o = overflow_q;

endmodule

// File: doc/uart_loop_fifo.md
# uart_loop_fifo

Byte buffer and launch controller between `uart_rx` and `uart_tx` in the UART loopback path. It captures each byte strobed out by the receiver into a circular FIFO and replays the bytes, in order, to the transmitter, issuing one start pulse per byte and waiting for the transmitter's finish pulse before launching the next. It absorbs bursts of received bytes while the transmitter is busy, and reports fill level and overflow.

## Interface
- `DATA_W`, 8: byte width.
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 entries (8).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  DATA_W  byte from `uart_rx`; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe from `uart_rx` finish output.
- `tx_done`  in  1  one-cycle strobe from `uart_tx` finish output.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `tx_start`  out  1  one-cycle launch strobe to `uart_tx`.
- `tx_data`  out  DATA_W  byte to `uart_tx`; registered, stable from `tx_start` until the next launch.
- `count`  out  DEPTH_LOG2+1  entries currently stored, 0..2^DEPTH_LOG2.
- `empty`  out  1  `count`==0.
- `full`  out  1  `count`==2^DEPTH_LOG2.
- `overflow`  out  1  sticky: a byte was dropped.

## Operation
- Storage: 2^DEPTH_LOG2 x DATA_W array, write pointer `wp` and read pointer `rp` of DEPTH_LOG2 bits; both wrap modulo depth naturally.
- Push: `rx_valid`=1 and (`full`=0 or pop in same cycle) → write `rx_data` at `wp`, `wp`+1.
- Drop: `rx_valid`=1, `full`=1, no pop that cycle → byte discarded, pointers unchanged, `overflow`<=1.
- `overflow` clears only on reset or `ovf_clr`=1; if `ovf_clr` and a drop occur in the same cycle, the drop wins (`overflow` stays 1).
- `count` next = count + push − pop; simultaneous push and pop leaves `count` unchanged.
- Launch FSM, states IDLE, LAUNCH, WAIT:
  - IDLE: if `empty`=0 → pop (`tx_data`<=mem[`rp`], `rp`+1), go LAUNCH; else stay.
  - LAUNCH: `tx_start`=1 for exactly this cycle; go WAIT unconditionally.
  - WAIT: stay until `tx_done`=1, then go IDLE.
- `tx_done` is ignored in IDLE and LAUNCH.
- `tx_start` is a registered output asserted only in LAUNCH; never asserted on consecutive cycles.
- Reset mid-operation: FIFO contents and any in-flight launch are abandoned; no `tx_start` after reset until a new byte is pushed.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, FSM=IDLE, `wp`=`rp`=0.
- Status outputs update on the edge after the push or pop that changes them.
- Empty FIFO, FSM in IDLE: push at edge E → `empty`=0 after E → pop at E+1 → `tx_start`=1 in the cycle after E+1. Latency from the `rx_valid` cycle to the `tx_start` cycle is 2 cycles.
- Back-to-back: `tx_done` sampled at edge D → IDLE after D → pop at D+1 → `tx_start`=1 in the cycle after D+1.
- Max throughput: one byte per transmitter frame plus 3 cycles.
- `rx_valid` may arrive in any FSM state and on consecutive cycles; each strobe is one byte.

## Test plan
- Single byte: reset, then `rx_valid` with 0x55 → `tx_start` 2 cycles later, `tx_data`=0x55; `count` goes 0→1→0; no second `tx_start` before `tx_done`.
- Burst ordering: push 0xA1,0xB2,0xC3 on consecutive cycles while `tx_done` is delayed 100 cycles per byte → three `tx_start` pulses with `tx_data` 0xA1,0xB2,0xC3 in order, each 2 cycles after the preceding `tx_done`.
- Full/overflow: hold `tx_done` low, push 10 bytes 0x00..0x09 → first byte in flight, `count`=8, `full`=1; byte 0x09 dropped, `overflow`=1; after `ovf_clr`, `overflow`=0; drained output is 0x00..0x08.
- Simultaneous push/pop at full: `full`=1, release `tx_done` so the IDLE pop coincides with `rx_valid` 0x7E → no drop, `overflow` stays 0, `count` stays 8, 0x7E emitted last.
- Pointer wrap: stream 20 bytes with the transmitter keeping up → all 20 emitted in order, `overflow`=0.
- Reset mid-operation: assert `rst` low in WAIT with `count`=3 → all outputs return to reset values immediately; no `tx_start` after release until a new `rx_valid`.
